watchdog_timer_mc: RTL and testbench

Multi-channel watchdog timer. Each channel counts clock cycles since its last kick and flags a fault when a run-time programmable timeout elapses. Optionally, a channel also flags a fault when it is kicked too early (window mode). It adds a pre-expiry warning, sticky per-channel status with explicit clear, and a single aggregated interrupt, so one instance can supervise several software/hardware agents in the system-control block.

---
 rtl/watchdog_timer_mc.sv | 125 ++++++++++++
 tb/tb_watchdog_timer_mc.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/watchdog_timer_mc.sv
// Multi-channel watchdog timer: per-channel timeout, early-kick window, pre-expiry warning,
// sticky status with explicit clear and one aggregated interrupt.
module watchdog_timer_mc #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
  input  logic [NUM_CH-1:0] kick,
  input  logic [NUM_CH-1:0] clr,
  input  logic [CNT_W-1:0]  timeout,
  input  logic [CNT_W-1:0]  warn_val,
  input  logic [CNT_W-1:0]  win_open,
  input  logic              win_en,
  output logic [NUM_CH-1:0] expired,
  output logic [NUM_CH-1:0] early,
  output logic [NUM_CH-1:0] warn,
  output logic              irq
);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFault
  } state_e;

  state_e            state_q [NUM_CH];
  state_e            state_d [NUM_CH];
  logic [CNT_W-1:0]  cnt_q   [NUM_CH];
  logic [CNT_W-1:0]  cnt_d   [NUM_CH];
  logic [NUM_CH-1:0] expired_q, expired_d;
  logic [NUM_CH-1:0] early_q, early_d;
  logic [CNT_W-1:0]  te_m1;

  // Last count value before expiry; timeouts below 2 clamp to 2.
  assign te_m1 = (timeout < CNT_W'(2)) ? CNT_W'(1) : timeout - CNT_W'(1);

  always_comb begin
    expired_d = expired_q;
    early_d   = early_q;
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        StIdle: begin
          cnt_d[i] = '0;
          if (clr[i]) begin
            expired_d[i] = 1'b0;
            early_d[i]   = 1'b0;
          end
          if (en[i]) begin
            state_d[i] = StRun;
          end
        end
        StRun: begin
          // Clear first so a fault detected this same cycle re-sets the sticky bit.
          if (clr[i]) begin
            expired_d[i] = 1'b0;
            early_d[i]   = 1'b0;
          end
          if (!en[i]) begin
            state_d[i] = StIdle;
            cnt_d[i]   = '0;
          end else if (kick[i] && win_en && (cnt_q[i] < win_open)) begin
            state_d[i] = StFault;
            early_d[i] = 1'b1;
          end else if (kick[i]) begin
            cnt_d[i] = '0;
          end else if (cnt_q[i] >= te_m1) begin
            state_d[i]   = StFault;
            expired_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        StFault: begin
          if (clr[i]) begin
            expired_d[i] = 1'b0;
            early_d[i]   = 1'b0;
            state_d[i]   = en[i] ? StRun : StIdle;
            cnt_d[i]     = '0;
          end else if (!en[i]) begin
            state_d[i] = StIdle;
            cnt_d[i]   = '0;
          end
        end
        default: begin
          state_d[i] = StIdle;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= StIdle;
        cnt_q[i]   <= '0;
      end
      expired_q <= '0;
      early_q   <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      expired_q <= expired_d;
      early_q   <= early_d;
    end
  end

  always_comb begin
    warn = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      warn[i] = (state_q[i] == StRun) && (cnt_q[i] >= warn_val);
    end
  end

  assign expired = expired_q;
  assign early   = early_q;
  assign irq     = |(expired_q | early_q);

endmodule

// File: tb/tb_watchdog_timer_mc.sv
// Directed self-checking bench for watchdog_timer_mc (2 channels, 8-bit counters).
module tb_watchdog_timer_mc;

  localparam int unsigned NumCh = 2;
  localparam int unsigned CntW  = 8;

  logic             clk;
  logic             rst;
  logic [NumCh-1:0] en, kick, clr;
  logic [CntW-1:0]  timeout, warn_val, win_open;
  logic             win_en;
  logic [NumCh-1:0] expired, early, warn;
  logic             irq;

  int tests = 0;
  int fails = 0;

  watchdog_timer_mc #(
    .NUM_CH(NumCh),
    .CNT_W (CntW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .kick    (kick),
    .clr     (clr),
    .timeout (timeout),
    .warn_val(warn_val),
    .win_open(win_open),
    .win_en  (win_en),
    .expired (expired),
    .early   (early),
    .warn    (warn),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; en = '0; kick = '0; clr = '0;
    timeout = 8'd10; warn_val = 8'd7; win_open = 8'd3; win_en = 1'b0;
    tick(1);
    rst = 1'b0;
    chk("rst_expired", expired, 2'b00);
    chk("rst_early", early, 2'b00);
    chk("rst_warn", warn, 2'b00);
    chk("rst_irq", irq, 1'b0);

    // Free-running channel 0: warn at +7, expiry at +10.
    en = 2'b01;
    tick(1);
    chk("t1_warn_c0", warn, 2'b00);
    tick(6);
    chk("t1_warn_c6", warn, 2'b00);
    tick(1);
    chk("t1_warn_c7", warn, 2'b01);
    tick(2);
    chk("t1_exp_c9", expired, 2'b00);
    chk("t1_irq_c9", irq, 1'b0);
    tick(1);
    chk("t1_expired", expired, 2'b01);
    chk("t1_irq", irq, 1'b1);
    chk("t1_early", early, 2'b00);
    chk("t1_warn_fault", warn, 2'b00);

    // Clear from FAULT with en=1 restarts the count.
    clr = 2'b01;
    tick(1);
    clr = 2'b00;
    chk("t5_clr_expired", expired, 2'b00);
    chk("t5_clr_irq", irq, 1'b0);
    tick(6);
    chk("t5_restart_c6", warn, 2'b00);
    tick(1);
    chk("t5_restart_c7", warn, 2'b01);

    // Kick exactly at count 9 beats the expiry.
    tick(2);
    kick = 2'b01;
    tick(1);
    kick = 2'b00;
    chk("t4_kick9_expired", expired, 2'b00);
    chk("t4_kick9_warn", warn, 2'b00);
    tick(9);
    chk("t4_c9_warn", warn, 2'b01);
    chk("t4_c9_expired", expired, 2'b00);
    tick(1);
    chk("t4_noKick_expired", expired, 2'b01);

    // Clear together with reset gives the reset result.
    clr = 2'b01;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    clr = 2'b00;
    chk("t5_rstclr_expired", expired, 2'b00);
    chk("t5_rstclr_irq", irq, 1'b0);
    chk("t5_rstclr_warn", warn, 2'b00);

    // Periodic kicks, window disabled.
    en = 2'b00;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    en = 2'b01;
    tick(1);
    for (int k = 0; k < 20; k++) begin
      tick(4);
      chk("t2_warn", warn, 2'b00);
      chk("t2_expired", expired, 2'b00);
      kick = 2'b01;
      tick(1);
      kick = 2'b00;
    end
    chk("t2_early", early, 2'b00);

    // Window mode: kick at count 1 is early.
    win_en = 1'b1;
    tick(1);
    kick = 2'b01;
    tick(1);
    kick = 2'b00;
    chk("t3_early", early, 2'b01);
    chk("t3_expired", expired, 2'b00);
    chk("t3_irq", irq, 1'b1);
    chk("t3_warn", warn, 2'b00);
    kick = 2'b01;
    tick(1);
    kick = 2'b00;
    chk("t3_rekick_early", early, 2'b01);
    tick(12);
    chk("t3_frozen_expired", expired, 2'b00);
    chk("t3_frozen_early", early, 2'b01);
    // Kick at count == O is inside the window.
    clr = 2'b01;
    tick(1);
    clr = 2'b00;
    chk("t3_clr_early", early, 2'b00);
    tick(3);
    kick = 2'b01;
    tick(1);
    kick = 2'b00;
    chk("t3_inwin_early", early, 2'b00);
    chk("t3_inwin_irq", irq, 1'b0);
    win_en = 1'b0;

    // Both channels running, reset mid-count.
    en = 2'b00;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    en = 2'b11;
    tick(1);
    tick(7);
    chk("t6_both_warn", warn, 2'b11);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    en = 2'b00;
    chk("t6_rst_warn", warn, 2'b00);
    chk("t6_rst_expired", expired, 2'b00);
    chk("t6_rst_early", early, 2'b00);
    chk("t6_rst_irq", irq, 1'b0);

    // Timeout 0 clamps to 2.
    timeout = 8'd0;
    en = 2'b01;
    tick(1);
    tick(1);
    chk("t6_clamp_c1", expired, 2'b00);
    tick(1);
    chk("t6_clamp_expired", expired, 2'b01);
    chk("t6_clamp_irq", irq, 1'b1);
    chk("t6_clamp_warn", warn, 2'b00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
